mem_dbus_ctrl: RTL and testbench

- MEM-stage data-bus controller, directly upstream of the MEM/WB pipeline register.
- Takes one load/store per instruction from the EX/MEM register and drives an SRAM-like data bus (req/addr_ok/data_ok).
- Raises mem_stop_wb while the access is outstanding, and delivers the raw load word on mem_rdata on the cycle the stall releases.
- Drains any bus transaction orphaned by a pipeline flush.

---
 rtl/mem_dbus_ctrl_pkg.sv | 18 +
 rtl/mem_dbus_ctrl_if.sv | 24 ++
 rtl/dbus_size_enc.sv | 18 +
 rtl/mem_dbus_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_dbus_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared constants for the MEM-stage data-bus controller: reset level, FSM state
// encodings and bus transfer-size codes.
package mem_dbus_ctrl_pkg;

    localparam logic        RST_ENABLE = 1'b0;
    localparam int unsigned BSEL_W     = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [1:0] DSIZE_BYTE = 2'd0;
    localparam logic [1:0] DSIZE_HALF = 2'd1;
    localparam logic [1:0] DSIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_dbus_ctrl_if.sv
// SRAM-like data bus between the MEM-stage controller (master) and the memory side (slave).
interface mem_dbus_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dbus_size_enc.sv
// Byte-lane select to bus transfer size. Irregular lane patterns fall back to a word.
module dbus_size_enc
    import mem_dbus_ctrl_pkg::*;
(
    input  logic [BSEL_W-1:0] bsel_i,
    output logic [1:0]        size_o
);

    always_comb begin
        size_o = DSIZE_WORD;
        case (bsel_i)
            4'b0011, 4'b1100:                   size_o = DSIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = DSIZE_BYTE;
            default:                            size_o = DSIZE_WORD;
        endcase
    end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: issues one load/store per instruction on the data bus,
// stalls MEM/WB until the response arrives and drains responses orphaned by a flush.
module mem_dbus_ctrl
    import mem_dbus_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              mem_ce,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [BSEL_W-1:0] mem_bsel,
    input  logic              flush,
    input  logic              stall_other,
    mem_dbus_ctrl_if.master   dbus,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stop_wb
);

    logic [2:0]        state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        size_enc;
    logic              issue;
    logic              stop;

    dbus_size_enc u_size_enc (
        .bsel_i (mem_bsel),
        .size_o (size_enc)
    );

    assign issue = mem_ce & ~flush;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_REQ;
                    wr_d    = mem_we;
                    size_d  = size_enc;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                end
            end
            S_REQ: begin
                // Withdrawing an unaccepted request is legal; an accepted one must be drained.
                if (dbus.data_addr_ok) begin
                    state_d = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dbus.data_data_ok) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        rdata_d = wr_q ? '0 : dbus.data_rdata;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                // Same instruction still sits in MEM while stall_other holds; do not re-issue.
                if (flush || !stall_other) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dbus.data_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stop = 1'b0;
        case (state_q)
            S_IDLE:                  stop = issue;
            S_REQ, S_WAIT, S_DRAIN:  stop = 1'b1;
            default:                 stop = 1'b0;
        endcase
    end

    // Gate the combinational issue path so the stall drops the instant reset asserts.
    assign mem_stop_wb = stop & (cpu_rst_n != RST_ENABLE);

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign dbus.data_req   = (state_q == S_REQ);
    assign dbus.data_wr    = wr_q;
    assign dbus.data_size  = size_q;
    assign dbus.data_addr  = addr_q;
    assign dbus.data_wdata = wdata_q;
    assign mem_rdata       = rdata_q;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Self-checking bench for mem_dbus_ctrl: directed scenarios plus randomized accesses
// checked against a cycle-count / last-word model of the bus controller.
module tb_mem_dbus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_bsel = '0;
    logic        flush = 1'b0;
    logic        stall_other = 1'b0;
    logic [31:0] mem_rdata;
    logic        mem_stop_wb;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_rdata = '0;

    mem_dbus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

    mem_dbus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_bsel    (mem_bsel),
        .flush       (flush),
        .stall_other (stall_other),
        .dbus        (dbus.master),
        .mem_rdata   (mem_rdata),
        .mem_stop_wb (mem_stop_wb)
    );

    always #5 clk = ~clk;

    // Reference: size from how many lanes are touched and whether a half is aligned.
    function automatic logic [1:0] ref_size(input logic [3:0] b);
        int n;
        n = $countones(b);
        if (n == 1) return 2'd0;
        if (n == 2 && (b == 4'b0011 || b == 4'b1100)) return 2'd1;
        return 2'd2;
    endfunction

    // Stalled cycles: issue cycle + request cycles + wait cycles, cut short by an early flush.
    function automatic int ref_stop(input int aw, input int dw, input int f);
        if (f == 0) return 0;
        if (f > 0 && f <= aw) return f + 1;
        return aw + dw + 2;
    endfunction

    function automatic int ref_req(input int aw, input int f);
        if (f == 0) return 0;
        if (f > 0 && f <= aw) return f;
        return aw + 1;
    endfunction

    // Drives one access with a parameterized slave; f = cycle index of flush (-1: none).
    task automatic run_access(
        input  logic        we,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [3:0]  bsel,
        input  int          aw,
        input  int          dw,
        input  logic [31:0] rdata,
        input  int          f,
        input  int          stall_cyc,
        output int          stop_n,
        output int          req_n,
        output int          done_n,
        output bit          changed,
        output bit          timeout,
        output logic [31:0] rel_rdata,
        output logic [1:0]  seen_size,
        output logic        seen_wr,
        output logic [31:0] seen_addr,
        output logic [31:0] seen_wdata,
        output int          extra_req
    );
        int c = 0;
        int rq = 0;
        int acc = -1;
        int stall_left = stall_cyc;
        bit pending = 0;
        bit released = 0;
        bit flushed = 0;
        stop_n = 0; done_n = 0; changed = 0; rel_rdata = '0; extra_req = 0;
        seen_size = '0; seen_wr = 1'b0; seen_addr = '0; seen_wdata = '0;
        while (!released && c < 40) begin
            @(negedge clk);
            mem_ce      = !flushed;
            mem_we      = we;
            mem_addr    = addr;
            mem_wdata   = wdata;
            mem_bsel    = bsel;
            flush       = (c == f);
            stall_other = 1'b0;
            dbus.data_addr_ok = dbus.data_req && (rq == aw);
            dbus.data_data_ok = pending && (c == acc + dw);
            dbus.data_rdata   = dbus.data_data_ok ? rdata : $urandom;
            #1;
            if (dbus.data_req) begin
                if (rq == 0) begin
                    seen_size = dbus.data_size; seen_wr = dbus.data_wr;
                    seen_addr = dbus.data_addr; seen_wdata = dbus.data_wdata;
                end
                rq++;
            end
            if (dbus.data_addr_ok) begin pending = 1; acc = c; end
            if (dbus.data_data_ok) pending = 0;
            if (mem_stop_wb) stop_n++;
            else begin
                if (done_n == 0) rel_rdata = mem_rdata;
                else if (mem_rdata !== rel_rdata) changed = 1;
                done_n++;
                if (stall_left > 0) begin stall_other = 1'b1; stall_left--; end
                else released = 1;
            end
            if (flush) flushed = 1;
            c++;
        end
        timeout = !released;
        req_n = rq;
        @(negedge clk);
        mem_ce = 1'b0; flush = 1'b0; stall_other = 1'b0;
        dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0;
        repeat (3) begin
            #1;
            if (dbus.data_req) extra_req++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (dbus.data_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b want=0", dbus.data_req); end
        total++; if (mem_stop_wb !== 1'b0) begin bad++; $display("FAIL rst_stop got=%0b want=0", mem_stop_wb); end
        total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h want=0", mem_rdata); end
        total++; if ({dbus.data_wr, dbus.data_size, dbus.data_addr, dbus.data_wdata} !== '0) begin
            bad++; $display("FAIL rst_bus got=%0h want=0", {dbus.data_wr, dbus.data_size, dbus.data_addr, dbus.data_wdata});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (dbus.data_req !== 1'b0 || mem_stop_wb !== 1'b0) begin
            bad++; $display("FAIL post_rst_idle got=%0b%0b want=00", dbus.data_req, mem_stop_wb);
        end
    endtask

    task automatic test_zero_wait_load();
        int sn, rn, dn, ex; bit ch, to; logic [31:0] rr, sa, sw; logic [1:0] ss; logic wr;
        run_access(1'b0, 32'h8000_0010, 32'h0, 4'b1111, 0, 1, 32'hDEAD_BEEF, -1, 0,
                   sn, rn, dn, ch, to, rr, ss, wr, sa, sw, ex);
        exp_rdata = 32'hDEAD_BEEF;
        total++; if (to) begin bad++; $display("FAIL zw_timeout got=1 want=0"); end
        total++; if (ss !== 2'd2) begin bad++; $display("FAIL zw_size got=%0d want=2", ss); end
        total++; if (wr !== 1'b0) begin bad++; $display("FAIL zw_wr got=%0b want=0", wr); end
        total++; if (sa !== 32'h8000_0010) begin bad++; $display("FAIL zw_addr got=%0h want=80000010", sa); end
        total++; if (sn != 3) begin bad++; $display("FAIL zw_stop_cycles got=%0d want=3", sn); end
        total++; if (rn != 1) begin bad++; $display("FAIL zw_req_cycles got=%0d want=1", rn); end
        total++; if (rr !== exp_rdata) begin bad++; $display("FAIL zw_rdata got=%0h want=%0h", rr, exp_rdata); end
        total++; if (ex != 0) begin bad++; $display("FAIL zw_rerequest got=%0d want=0", ex); end
    endtask

    task automatic test_slow_byte_store();
        int sn, rn, dn, ex; bit ch, to; logic [31:0] rr, sa, sw; logic [1:0] ss; logic wr;
        run_access(1'b1, 32'h8000_0102, 32'h00AB_0000, 4'b0100, 3, 2, 32'h5555_AAAA, -1, 0,
                   sn, rn, dn, ch, to, rr, ss, wr, sa, sw, ex);
        exp_rdata = 32'h0;
        total++; if (to) begin bad++; $display("FAIL st_timeout got=1 want=0"); end
        total++; if (ss !== 2'd0) begin bad++; $display("FAIL st_size got=%0d want=0", ss); end
        total++; if (wr !== 1'b1) begin bad++; $display("FAIL st_wr got=%0b want=1", wr); end
        total++; if (sw !== 32'h00AB_0000) begin bad++; $display("FAIL st_wdata got=%0h want=ab0000", sw); end
        total++; if (rn != 4) begin bad++; $display("FAIL st_req_cycles got=%0d want=4", rn); end
        total++; if (sn != 7) begin bad++; $display("FAIL st_stop_cycles got=%0d want=7", sn); end
        total++; if (rr !== 32'h0) begin bad++; $display("FAIL st_rdata got=%0h want=0", rr); end
    endtask

    task automatic test_stall_other();
        int sn, rn, dn, ex; bit ch, to; logic [31:0] rr, sa, sw; logic [1:0] ss; logic wr;
        run_access(1'b0, 32'h8000_0200, 32'h0, 4'b1100, 0, 1, 32'hC0FF_EE11, -1, 2,
                   sn, rn, dn, ch, to, rr, ss, wr, sa, sw, ex);
        exp_rdata = 32'hC0FF_EE11;
        total++; if (to) begin bad++; $display("FAIL so_timeout got=1 want=0"); end
        total++; if (ss !== 2'd1) begin bad++; $display("FAIL so_size got=%0d want=1", ss); end
        total++; if (dn != 3) begin bad++; $display("FAIL so_done_cycles got=%0d want=3", dn); end
        total++; if (ch) begin bad++; $display("FAIL so_rdata_stable got=changed want=stable"); end
        total++; if (rn + ex != 1) begin bad++; $display("FAIL so_one_request got=%0d want=1", rn + ex); end
        total++; if (mem_rdata !== exp_rdata) begin bad++; $display("FAIL so_rdata got=%0h want=%0h", mem_rdata, exp_rdata); end
    endtask

    task automatic test_flush_wait();
        int sn, rn, dn, ex; bit ch, to; logic [31:0] rr, sa, sw; logic [1:0] ss; logic wr;
        run_access(1'b0, 32'h8000_0300, 32'h0, 4'b1111, 0, 3, 32'h1234_5678, 2, 0,
                   sn, rn, dn, ch, to, rr, ss, wr, sa, sw, ex);
        total++; if (to) begin bad++; $display("FAIL fw_timeout got=1 want=0"); end
        total++; if (sn != 5) begin bad++; $display("FAIL fw_stop_cycles got=%0d want=5", sn); end
        total++; if (rn + ex != 1) begin bad++; $display("FAIL fw_no_rerequest got=%0d want=1", rn + ex); end
        total++; if (mem_rdata !== exp_rdata) begin bad++; $display("FAIL fw_rdata got=%0h want=%0h", mem_rdata, exp_rdata); end
    endtask

    task automatic test_flush_req();
        int sn, rn, dn, ex; bit ch, to; logic [31:0] rr, sa, sw; logic [1:0] ss; logic wr;
        run_access(1'b0, 32'h8000_0400, 32'h0, 4'b0001, 4, 1, 32'h7777_7777, 2, 0,
                   sn, rn, dn, ch, to, rr, ss, wr, sa, sw, ex);
        total++; if (to) begin bad++; $display("FAIL fr_timeout got=1 want=0"); end
        total++; if (rn != 2) begin bad++; $display("FAIL fr_req_cycles got=%0d want=2", rn); end
        total++; if (sn != 3) begin bad++; $display("FAIL fr_stop_cycles got=%0d want=3", sn); end
        total++; if (ex != 0) begin bad++; $display("FAIL fr_rerequest got=%0d want=0", ex); end
        total++; if (mem_rdata !== exp_rdata) begin bad++; $display("FAIL fr_rdata got=%0h want=%0h", mem_rdata, exp_rdata); end
    endtask

    task automatic test_random();
        logic [3:0] bsel_tab [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        for (int i = 0; i < 24; i++) begin
            int sn, rn, dn, ex; bit ch, to; logic [31:0] rr, sa, sw; logic [1:0] ss; logic wr;
            logic we; logic [31:0] addr, wdata, rdata; logic [3:0] bsel;
            int aw, dw, f, st;
            we    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            bsel  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : bsel_tab[$urandom_range(0, 6)];
            aw    = $urandom_range(0, 3);
            dw    = $urandom_range(1, 3);
            f     = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, aw + 1 + dw);
            st    = (f < 0) ? $urandom_range(0, 2) : 0;
            run_access(we, addr, wdata, bsel, aw, dw, rdata, f, st,
                       sn, rn, dn, ch, to, rr, ss, wr, sa, sw, ex);
            if (f < 0) exp_rdata = we ? 32'h0 : rdata;
            total++; if (to) begin bad++; $display("FAIL rnd%0d_timeout got=1 want=0", i); end
            total++; if (sn != ref_stop(aw, dw, f)) begin
                bad++; $display("FAIL rnd%0d_stop got=%0d want=%0d", i, sn, ref_stop(aw, dw, f));
            end
            total++; if (rn != ref_req(aw, f) || ex != 0) begin
                bad++; $display("FAIL rnd%0d_req got=%0d+%0d want=%0d+0", i, rn, ex, ref_req(aw, f));
            end
            total++; if (mem_rdata !== exp_rdata) begin
                bad++; $display("FAIL rnd%0d_rdata got=%0h want=%0h", i, mem_rdata, exp_rdata);
            end
            if (rn > 0) begin
                total++; if ({ss, wr, sa, sw} !== {ref_size(bsel), we, addr, wdata}) begin
                    bad++; $display("FAIL rnd%0d_fields got=%0h want=%0h", i, {ss, wr, sa, sw},
                                    {ref_size(bsel), we, addr, wdata});
                end
            end
            if (f < 0) begin
                total++; if (ch) begin bad++; $display("FAIL rnd%0d_stable got=changed want=stable", i); end
            end
        end
    endtask

    task automatic test_async_reset();
        int sn, rn, dn, ex; bit ch, to; logic [31:0] rr, sa, sw; logic [1:0] ss; logic wr;
        run_access(1'b0, 32'h8000_0500, 32'h0, 4'b1111, 0, 1, 32'hA5A5_0001, -1, 0,
                   sn, rn, dn, ch, to, rr, ss, wr, sa, sw, ex);
        @(negedge clk);
        mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0040; mem_wdata = 32'h1111_2222;
        mem_bsel = 4'hF;
        @(negedge clk);
        dbus.data_addr_ok = dbus.data_req;
        @(negedge clk);
        dbus.data_addr_ok = 1'b0;
        #1;
        total++; if (mem_stop_wb !== 1'b1 || dbus.data_req !== 1'b0) begin
            bad++; $display("FAIL ar_in_wait got=%0b%0b want=10", mem_stop_wb, dbus.data_req);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({dbus.data_req, dbus.data_wr, dbus.data_size, dbus.data_addr, dbus.data_wdata} !== '0) begin
            bad++; $display("FAIL ar_bus got=%0h want=0",
                            {dbus.data_req, dbus.data_wr, dbus.data_size, dbus.data_addr, dbus.data_wdata});
        end
        total++; if (mem_stop_wb !== 1'b0) begin bad++; $display("FAIL ar_stop got=%0b want=0", mem_stop_wb); end
        total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL ar_rdata got=%0h want=0", mem_rdata); end
        mem_ce = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        @(negedge clk); #1;
        total++; if (dbus.data_req !== 1'b0 || mem_stop_wb !== 1'b0) begin
            bad++; $display("FAIL ar_after got=%0b%0b want=00", dbus.data_req, mem_stop_wb);
        end
    endtask

    initial begin
        dbus.data_addr_ok = 1'b0;
        dbus.data_data_ok = 1'b0;
        dbus.data_rdata   = '0;
        test_reset();
        test_zero_wait_load();
        test_slow_byte_store();
        test_stall_other();
        test_flush_wait();
        test_flush_req();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
